buffer_flow_ctrl: RTL and testbench
===================================

BUFFER_FLOW_CTRL -- requirements
Module: buffer_flow_ctrl

Interface
REQ-001 Parameter CAPACITY, default 8: maximum slots held (1..255).
REQ-002 Parameter MAX_IN, default 4: maximum entries accepted per cycle (1..CAPACITY).
REQ-003 Parameter MAX_OUT, default 4: maximum entries offered per cycle (1..CAPACITY).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstN  in  1  reset, asynchronous assert, active-low.
REQ-006 prevSending  in  8  entries delivered by upstream this cycle.
REQ-007 nextAccepting  in  8  entries downstream can take this cycle.
REQ-008 kill  in  8  entries invalidated this cycle, taken from the youngest end.
REQ-009 killAll  in  1  invalidate all held entries this cycle.
REQ-010 stallReq  in  1  level; freeze traffic in both directions.
REQ-011 drainReq  in  1  pulse; stop accepting and empty the buffer.
REQ-012 canAccept  out  8  entries upstream may send this cycle.
REQ-013 wantSend  out  8  entries offered downstream this cycle.
REQ-014 sending  out  8  entries actually passed downstream this cycle.
REQ-015 fullCount  out  8  registered occupancy.
REQ-016 state  out  2  00 RUN, 01 HOLD, 10 DRAIN.
REQ-017 drainDone  out  1  one-cycle pulse when a drain completes.

Function
REQ-018 living SHALL be 0 if killAll; otherwise fullCount-kill, clamped at 0 when kill>fullCount.
REQ-019 wantSend SHALL be 0 in HOLD; otherwise min(MAX_OUT, living).
REQ-020 sending SHALL be min(wantSend, nextAccepting); all outputs are combinational from registered state and current inputs.
REQ-021 canAccept SHALL be 0 in HOLD or DRAIN, or while drainReq is high; otherwise min(MAX_IN, CAPACITY-fullCount).
REQ-022 On each clock, fullCount SHALL load living-sending+prevSending; prevSending is counted only when canAccept>0, otherwise it is ignored.
REQ-023 Arithmetic SHALL be 9-bit internally; a sum above CAPACITY SHALL clamp to CAPACITY.
REQ-024 Transitions, evaluated with drainReq priority over stallReq:
- RUN->DRAIN on drainReq.
- RUN->HOLD on stallReq.
- HOLD->RUN when stallReq is low.
- HOLD->DRAIN on drainReq.
REQ-025 DRAIN->RUN SHALL occur in the cycle the next fullCount equals 0; drainDone SHALL pulse high during that cycle.
REQ-026 killAll in DRAIN SHALL complete the drain in that cycle, with the drainDone pulse.
REQ-027 stallReq in DRAIN SHALL force wantSend=0 while state remains DRAIN.
REQ-028 killAll with nonzero prevSending SHALL give next fullCount=prevSending if canAccept>0, else 0.
REQ-029 Full: fullCount=CAPACITY gives canAccept=0. Empty: fullCount=0 gives wantSend=0 and sending=0.
REQ-030 drainReq while already in DRAIN SHALL be ignored.
REQ-031 drainReq with fullCount=0 and no incoming entries SHALL pulse drainDone in the next cycle and return to RUN.

Reset
REQ-032 While rstN=0: fullCount=0, state=RUN, drainDone=0.
REQ-033 While rstN=0, canAccept, wantSend and sending SHALL be 0, regardless of any operation in progress, including a drain.
REQ-034 After rstN rises, the first edge SHALL behave as RUN with fullCount=0.

Configuration
REQ-035 With BUFFER_FLOW_OVF_CHECK_EN defined, the block SHALL add output ovfErr (1 bit). ovfErr is a sticky flag set when prevSending>canAccept or the unclamped sum exceeds CAPACITY, and cleared only by reset.
REQ-036 Without BUFFER_FLOW_OVF_CHECK_EN, there SHALL be no ovfErr port, and clamping per REQ-023 is the only protection.

Verification
REQ-037 Defaults; prevSending=4 for 2 cycles, nextAccepting=0 -> fullCount 4 then 8; canAccept 4, 4, then 0.
REQ-038 fullCount=8, nextAccepting=3 -> wantSend=4, sending=3, next fullCount=5.
REQ-039 fullCount=6, kill=2, nextAccepting=8 -> living=4, sending=4, next fullCount=0.
REQ-040 fullCount=5, drainReq pulse, nextAccepting=4 -> state DRAIN, canAccept=0, fullCount 1 then 0, drainDone pulse, state RUN.
REQ-041 fullCount=7, stallReq held 3 cycles -> wantSend=0, canAccept=0, fullCount stays 7; after stallReq drops, RUN resumes.
REQ-042 DRAIN with fullCount=3, killAll=1 -> next fullCount=0, drainDone pulse; rstN low mid-drain -> state RUN, fullCount 0 immediately.

Source files
------------

// File: rtl/buffer_flow_ctrl.sv
// buffer_flow_ctrl: occupancy-tracking flow controller for an elastic buffer.
// Tracks how many slots are held, tells upstream how many entries it may send
// and offers entries downstream, with stall (HOLD) and drain (DRAIN) modes.
// Optional feature: define BUFFER_FLOW_OVF_CHECK_EN to add the sticky ovfErr
// output.
//
// Flow handshake: every cycle upstream may deliver up to canAccept entries
// (prevSending); deliveries are counted only when canAccept is nonzero.
// Downstream is offered wantSend entries and takes min(wantSend,
// nextAccepting), reported as sending. Transfers on both sides complete on
// the rising clock edge.
module buffer_flow_ctrl #(
  parameter int unsigned CAPACITY = 8,
  parameter int unsigned MAX_IN   = 4,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] prevSending,
  input  logic [7:0] nextAccepting,
  input  logic [7:0] kill,
  input  logic       killAll,
  input  logic       stallReq,
  input  logic       drainReq,
  output logic [7:0] canAccept,
  output logic [7:0] wantSend,
  output logic [7:0] sending,
  output logic [7:0] fullCount,
  output logic [1:0] state,
  output logic       drainDone
`ifdef BUFFER_FLOW_OVF_CHECK_EN
  ,
  output logic       ovfErr
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam logic [8:0] CAP9     = 9'(CAPACITY);
  localparam logic [8:0] MAX_IN9  = 9'(MAX_IN);
  localparam logic [8:0] MAX_OUT9 = 9'(MAX_OUT);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;

  // 9-bit working values so subtraction and addition never wrap
  logic [8:0] cnt9, kill9, prev9, nacc9;
  logic [8:0] living, want, send, room, accept, incoming, sum;
  logic       done;

  // Occupancy arithmetic: survivors after kills, offers, acceptance, next count
  always_comb begin
    cnt9     = {1'b0, count_q};
    kill9    = {1'b0, kill};
    prev9    = {1'b0, prevSending};
    nacc9    = {1'b0, nextAccepting};
    living   = '0;
    want     = '0;
    send     = '0;
    room     = '0;
    accept   = '0;
    incoming = '0;
    sum      = '0;
    count_d  = count_q;

    if (!killAll && (kill9 <= cnt9)) living = cnt9 - kill9;

    // HOLD freezes the output side; a stall during DRAIN does the same
    if ((state_q != ST_HOLD) && !((state_q == ST_DRAIN) && stallReq))
      want = (living < MAX_OUT9) ? living : MAX_OUT9;

    send = (want < nacc9) ? want : nacc9;

    room = CAP9 - cnt9;
    if ((state_q == ST_RUN) && !drainReq)
      accept = (room < MAX_IN9) ? room : MAX_IN9;

    // Upstream deliveries are ignored entirely when nothing was granted
    if (accept != 9'd0) incoming = prev9;

    sum     = living - send + incoming;
    count_d = (sum > CAP9) ? CAP9[7:0] : sum[7:0];
  end

  // Mode FSM: drain beats stall; a drain ends when the next count is zero
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (drainReq)      state_d = ST_DRAIN;
        else if (stallReq) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (drainReq)       state_d = ST_DRAIN;
        else if (!stallReq) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (count_d == 8'd0) begin
          state_d = ST_RUN;
          done    = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    canAccept = '0;
    wantSend  = '0;
    sending   = '0;
    drainDone = 1'b0;
    if (rstN) begin
      canAccept = accept[7:0];
      wantSend  = want[7:0];
      sending   = send[7:0];
      drainDone = done;
    end
  end

  assign fullCount = count_q;
  assign state     = state_q;

  // State and occupancy registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef BUFFER_FLOW_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky overflow flag: over-delivery or an unclamped sum beyond capacity
  always_comb begin
    ovf_d = ovf_q;
    if ((prev9 > accept) || (sum > CAP9)) ovf_d = 1'b1;
  end

  // Overflow flag register, cleared only by reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovfErr = ovf_q;
`endif

endmodule

// File: tb/tb_buffer_flow_ctrl.sv
// tb_buffer_flow_ctrl: directed vector table, multi-cycle reset/drain
// sequences and a randomized run against a behavioural occupancy model.
module tb_buffer_flow_ctrl;

  localparam int CAP  = 8;
  localparam int MIN_ = 4;
  localparam int MOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] prevSending, nextAccepting, kill;
  logic       killAll, stallReq, drainReq;
  logic [7:0] canAccept, wantSend, sending, fullCount;
  logic [1:0] state;
  logic       drainDone;
`ifdef BUFFER_FLOW_OVF_CHECK_EN
  logic       ovfErr;
`endif

  buffer_flow_ctrl #(.CAPACITY(CAP), .MAX_IN(MIN_), .MAX_OUT(MOUT)) dut (
    .clk(clk), .rstN(rstN),
    .prevSending(prevSending), .nextAccepting(nextAccepting), .kill(kill),
    .killAll(killAll), .stallReq(stallReq), .drainReq(drainReq),
    .canAccept(canAccept), .wantSend(wantSend), .sending(sending),
    .fullCount(fullCount), .state(state), .drainDone(drainDone)
`ifdef BUFFER_FLOW_OVF_CHECK_EN
    , .ovfErr(ovfErr)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int ps, input int na, input int kl,
                       input bit ka, input bit st, input bit dr);
    prevSending   = 8'(ps);
    nextAccepting = 8'(na);
    kill          = 8'(kl);
    killAll       = ka;
    stallReq      = st;
    drainReq      = dr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int ps, na, kl;
    bit ka, st, dr;
    int ca, ws, sd, fc, stt;
    bit dd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int ps, input int na, input int kl, input bit ka,
                     input bit st, input bit dr, input int ca, input int ws,
                     input int sd, input int fc, input int stt, input bit dd);
    vec_t v;
    v.ps = ps; v.na = na; v.kl = kl; v.ka = ka; v.st = st; v.dr = dr;
    v.ca = ca; v.ws = ws; v.sd = sd; v.fc = fc; v.stt = stt; v.dd = dd;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  int m_fc, m_st;
  int m_ca, m_ws, m_sd, m_dd, m_nfc, m_nst;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model of one cycle: m_st is 0 RUN, 1 HOLD, 2 DRAIN
  task automatic model(input int ps, input int na, input int kl,
                       input bit ka, input bit st, input bit dr);
    int living, total;
    living = ka ? 0 : ((kl > m_fc) ? 0 : m_fc - kl);
    m_ws = ((m_st == 1) || (m_st == 2 && st)) ? 0 : imin(MOUT, living);
    m_sd = imin(m_ws, na);
    m_ca = ((m_st != 0) || dr) ? 0 : imin(MIN_, CAP - m_fc);
    total = living - m_sd + ((m_ca > 0) ? ps : 0);
    m_nfc = (total > CAP) ? CAP : total;
    m_dd = 0;
    if (m_st == 2) begin
      m_nst = (m_nfc == 0) ? 0 : 2;
      m_dd  = (m_nfc == 0);
    end else if (dr) m_nst = 2;
    else m_nst = st ? 1 : 0;
  endtask

  // ---------------- test ----------------
  initial begin
    drive(4, 8, 0, 0, 0, 1);

    // reset state with active inputs present
    #12;
    chk("rst_fc", fullCount, 0);
    chk("rst_state", state, 0);
    chk("rst_ca", canAccept, 0);
    chk("rst_ws", wantSend, 0);
    chk("rst_dd", drainDone, 0);
    do_reset();

    //   ps na kl ka st dr | ca ws sd fc st dd
    add(4, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0,   4, 4, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 4, 0, 8, 0, 0);  // full
    add(0, 3, 0, 0, 0, 0,   0, 4, 3, 8, 0, 0);
    add(1, 0, 0, 0, 0, 0,   3, 4, 0, 5, 0, 0);
    add(0, 8, 2, 0, 0, 0,   2, 4, 4, 6, 0, 0);  // kill 2 of 6
    add(4, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,   4, 4, 0, 4, 0, 0);
    add(0, 4, 0, 0, 0, 1,   0, 4, 4, 5, 0, 0);  // drain request
    add(0, 4, 0, 0, 0, 0,   0, 1, 1, 1, 2, 1);  // drain completes
    add(4, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0,   4, 4, 0, 4, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 4, 0, 7, 0, 0);  // stall raised
    add(2, 8, 0, 0, 1, 0,   0, 0, 0, 7, 1, 0);  // HOLD ignores traffic
    add(0, 8, 0, 0, 1, 0,   0, 0, 0, 7, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 1, 0);
    add(0, 4, 0, 0, 0, 0,   1, 4, 4, 7, 0, 0);  // RUN resumes
    add(0, 0, 0, 0, 0, 1,   0, 3, 0, 3, 0, 0);
    add(0, 0, 0, 1, 0, 1,   0, 0, 0, 3, 2, 1);  // killAll ends drain
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);  // drain when empty
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 1);
    add(4, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 4, 0, 4, 0, 0);
    add(0, 8, 0, 0, 1, 0,   0, 0, 0, 4, 2, 0);  // stall in DRAIN
    add(0, 8, 0, 0, 0, 0,   0, 4, 4, 4, 2, 1);
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(0, 8, 6, 0, 0, 0,   4, 0, 0, 4, 0, 0);  // kill beyond count
    add(3, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0);
    add(2, 0, 0, 1, 0, 0,   4, 0, 0, 3, 0, 0);  // killAll with input
    add(0, 0, 0, 0, 0, 0,   4, 2, 0, 2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ps, vecs[i].na, vecs[i].kl, vecs[i].ka, vecs[i].st, vecs[i].dr);
      #1;
      chk($sformatf("v%0d_ca", i), canAccept, vecs[i].ca);
      chk($sformatf("v%0d_ws", i), wantSend, vecs[i].ws);
      chk($sformatf("v%0d_sd", i), sending, vecs[i].sd);
      chk($sformatf("v%0d_fc", i), fullCount, vecs[i].fc);
      chk($sformatf("v%0d_st", i), state, vecs[i].stt);
      chk($sformatf("v%0d_dd", i), drainDone, vecs[i].dd);
    end

    // reset asserted in the middle of a stalled drain (count is 2 here)
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(4, 8, 0, 0, 1, 0);
    #1;
    chk("mid_state", state, 2);
    chk("mid_ws", wantSend, 0);
    chk("mid_fc", fullCount, 2);
    #1 rstN = 1'b0;
    #1;
    chk("mid_rst_fc", fullCount, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_ca", canAccept, 0);
    chk("mid_rst_ws", wantSend, 0);
    chk("mid_rst_sd", sending, 0);
    chk("mid_rst_dd", drainDone, 0);
    @(negedge clk);
    rstN = 1'b1;
    drive(4, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_ca", canAccept, 4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_fc", fullCount, 4);
    chk("post_rst_state", state, 0);

    // randomized run against the model
    do_reset();
    m_fc = 0;
    m_st = 0;
    for (int c = 0; c < 2000; c++) begin
      int ps, na, kl;
      bit ka, st, dr;
      @(negedge clk);
      if (exp_q.size() > 0) chk("rnd_fc", fullCount, exp_q.pop_front());
      ps = $urandom_range(0, 6);
      na = $urandom_range(0, 6);
      kl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0;
      ka = ($urandom_range(0, 31) == 0);
      st = ($urandom_range(0, 7) == 0);
      dr = ($urandom_range(0, 15) == 0);
      drive(ps, na, kl, ka, st, dr);
      #1;
      model(ps, na, kl, ka, st, dr);
      chk("rnd_ca", canAccept, m_ca);
      chk("rnd_ws", wantSend, m_ws);
      chk("rnd_sd", sending, m_sd);
      chk("rnd_state", state, m_st);
      chk("rnd_dd", drainDone, m_dd);
      exp_q.push_back(8'(m_nfc));
      m_fc = m_nfc;
      m_st = m_nst;
    end
    @(negedge clk);
    if (exp_q.size() > 0) chk("rnd_fc_last", fullCount, exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
